ps2_keypad: RTL

PS/2 keyboard front end for the CHIP-8 core. It receives scan-code set 2 frames from the PS2_CLK/PS2_DATA pins and tracks make and break codes. It maintains the 16-key CHIP-8 hex keypad state that the CPU reads for SKP/SKNP/LD Vx,K. It runs in the 25 MHz pixel/system clock domain, and the PS/2 pins are treated as asynchronous.

---
 rtl/ps2_keypad_pkg.sv | 35 +++
 rtl/ps2_rx.sv | 115 +++++++++++
 rtl/ps2_keypad.sv | 69 ++++++
 3 files changed

// File: rtl/ps2_keypad_pkg.sv
// Shared scan-code constants, receiver state encoding and the set 2 -> CHIP-8 key map.
package ps2_keypad_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // Returns {hit, key}; hit=0 for any code that is not on the hex pad.
  function automatic logic [4:0] key_map(input logic [7:0] code);
    logic [4:0] r;
    r = 5'h00;
    case (code)
      8'h16: r = {1'b1, 4'h1};
      8'h1E: r = {1'b1, 4'h2};
      8'h26: r = {1'b1, 4'h3};
      8'h25: r = {1'b1, 4'hC};
      8'h15: r = {1'b1, 4'h4};
      8'h1D: r = {1'b1, 4'h5};
      8'h24: r = {1'b1, 4'h6};
      8'h2D: r = {1'b1, 4'hD};
      8'h1C: r = {1'b1, 4'h7};
      8'h1B: r = {1'b1, 4'h8};
      8'h23: r = {1'b1, 4'h9};
      8'h2B: r = {1'b1, 4'hE};
      8'h1A: r = {1'b1, 4'hA};
      8'h22: r = {1'b1, 4'h0};
      8'h21: r = {1'b1, 4'hB};
      8'h2A: r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: pin synchronisers, PS2_CLK deglitch filter, frame FSM with inter-edge timeout.
module ps2_rx
  import ps2_keypad_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       gclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_error
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_s, data_s;
  logic                   filt;
  logic [FCW-1:0]         fcnt;
  logic                   fall;

  rx_state_t state;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           par;
  logic [TCW-1:0] tcnt;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  always_ff @(posedge gclk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // fcnt counts consecutive samples that disagree with the filtered level.
  always_ff @(posedge gclk) begin
    if (rst) begin
      filt <= 1'b1;
      fcnt <= '0;
      fall <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s == filt) begin
        fcnt <= '0;
      end else if (fcnt == FCW'(FILTER_LEN - 1)) begin
        filt <= clk_s;
        fcnt <= '0;
        fall <= filt & ~clk_s;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      state       <= RX_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      tcnt        <= '0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (state == RX_IDLE || fall) tcnt <= '0;
      else                          tcnt <= tcnt + 1'b1;

      if (state != RX_IDLE && !fall && tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
        state       <= RX_IDLE;
        frame_error <= 1'b1;
      end else if (fall) begin
        case (state)
          RX_IDLE: if (!data_s) begin
            state   <= RX_DATA;
            bit_cnt <= '0;
          end
          RX_DATA: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            par   <= data_s;
            state <= RX_STOP;
          end
          RX_STOP: begin
            state <= RX_IDLE;
            if (data_s && (^{shreg, par})) begin
              byte_data  <= shreg;
              byte_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_keypad.sv
// CHIP-8 hex keypad from a PS/2 keyboard: E0/F0 prefix decoding and the held-key register.
module ps2_keypad
  import ps2_keypad_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic        CLK_25MHZ,
  input  logic        RESET,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  output logic [15:0] KEYS,
  output logic        KEY_EVENT,
  output logic [3:0]  KEY_CODE,
  output logic        KEY_PRESSED,
  output logic        FRAME_ERROR
);

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_error;
  logic       brk, ext;
  logic [4:0] hit;

  ps2_rx #(
    .SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .gclk(CLK_25MHZ), .rst(RESET), .ps2_clk(PS2_CLK), .ps2_data(PS2_DATA),
    .byte_data(byte_data), .byte_valid(byte_valid), .frame_error(frame_error)
  );

  assign FRAME_ERROR = frame_error;
  assign hit         = key_map(byte_data);

  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      KEYS        <= '0;
      KEY_EVENT   <= 1'b0;
      KEY_CODE    <= '0;
      KEY_PRESSED <= 1'b0;
      brk         <= 1'b0;
      ext         <= 1'b0;
    end else begin
      KEY_EVENT <= 1'b0;
      if (frame_error) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (byte_valid) begin
        if (byte_data == PS2_EXT) begin
          ext <= 1'b1;
        end else if (byte_data == PS2_BREAK) begin
          brk <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          // Repeats and releases of unheld keys leave state and event untouched.
          if (!ext && hit[4] && KEYS[hit[3:0]] != !brk) begin
            KEYS[hit[3:0]] <= !brk;
            KEY_EVENT      <= 1'b1;
            KEY_CODE       <= hit[3:0];
            KEY_PRESSED    <= !brk;
          end
        end
      end
    end
  end

endmodule
